// File: rtl/audio_pkg.sv
//------------------------------------------------------------------------------
// Module   : audio_pkg
// Purpose  : Shared constants and helpers for the time-slotted audio mixer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package audio_pkg;

  localparam int ACC_W = 10;
  localparam int OUT_W = 9;

  localparam logic [1:0] SRC_A    = 2'd0;
  localparam logic [1:0] SRC_B    = 2'd1;
  localparam logic [1:0] SRC_C    = 2'd2;
  localparam logic [1:0] SRC_BEEP = 2'd3;

  localparam int CFG_L   = 3;
  localparam int CFG_R   = 2;
  localparam int CFG_ATT = 0;

  typedef logic [3:0] cfg_t;

  // Index 3 (beeper) is the most significant nibble.
  localparam logic [3:0][3:0] CFG_DEFAULT = {4'b1100, 4'b0100, 4'b1100, 4'b1000};

  localparam logic [7:0] BEEP_LVL_0  = 8'd0;
  localparam logic [7:0] BEEP_LVL_16 = 8'd16;
  localparam logic [7:0] BEEP_LVL_32 = 8'd32;
  localparam logic [7:0] BEEP_LVL_48 = 8'd48;

  function automatic logic [7:0] beep_level(input logic ear, input logic mic);
    case ({ear, mic})
      2'b01:   return BEEP_LVL_16;
      2'b10:   return BEEP_LVL_32;
      2'b11:   return BEEP_LVL_48;
      default: return BEEP_LVL_0;
    endcase
  endfunction

  function automatic logic [ACC_W-1:0] src_term(input logic [7:0] level,
                                                 input logic [1:0] att);
    return {2'b00, level >> att};
  endfunction

  function automatic logic [OUT_W-1:0] saturate(input logic [ACC_W-1:0] acc,
                                                 input logic mute);
    if (mute)
      return '0;
    if (acc > ACC_W'(511))
      return '1;
    return acc[OUT_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/audio_tick_gen.sv
//------------------------------------------------------------------------------
// Module   : audio_tick_gen
// Purpose  : Sample-rate divider; tick is high on the last count of each frame.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module audio_tick_gen #(
  parameter int SAMPLE_DIV = 64
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q + CNT_W'(1);
    if (div_cnt_q == C_LAST)
      div_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_cnt_q <= '0;
    else
      div_cnt_q <= div_cnt_d;
  end

  assign tick = (div_cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/audio_mix_scheduler.sv
//------------------------------------------------------------------------------
// Module   : audio_mix_scheduler
// Purpose  : Four-slot shared-adder mixer of AY channels and beeper into L/R.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module audio_mix_scheduler
  import audio_pkg::*;
#(
  parameter int SAMPLE_DIV = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ear,
  input  logic             mic,
  input  logic [7:0]       ay_cha,
  input  logic [7:0]       ay_chb,
  input  logic [7:0]       ay_chc,
  input  logic             mute,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [3:0]       cfg_data,
  output logic [OUT_W-1:0] audio_l,
  output logic [OUT_W-1:0] audio_r,
  output logic             audio_valid
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_SAT  = 2'd2;

  logic tick;

  audio_tick_gen #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  logic [1:0]       state_q,    state_d;
  logic [1:0]       slot_q,     slot_d;
  logic [3:0][3:0]  cfg_q,      cfg_d;
  logic [3:0][3:0]  snap_cfg_q, snap_cfg_d;
  logic [3:0][7:0]  snap_lvl_q, snap_lvl_d;
  logic             snap_mute_q, snap_mute_d;
  logic [ACC_W-1:0] acc_l_q,    acc_l_d;
  logic [ACC_W-1:0] acc_r_q,    acc_r_d;
  logic [OUT_W-1:0] audio_l_q,  audio_l_d;
  logic [OUT_W-1:0] audio_r_q,  audio_r_d;
  logic             valid_q,    valid_d;
  logic [ACC_W-1:0] term;
  cfg_t             slot_cfg;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    cfg_d       = cfg_q;
    snap_cfg_d  = snap_cfg_q;
    snap_lvl_d  = snap_lvl_q;
    snap_mute_d = snap_mute_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    audio_l_d   = audio_l_q;
    audio_r_d   = audio_r_q;
    valid_d     = 1'b0;
    slot_cfg    = snap_cfg_q[slot_q];
    term        = src_term(snap_lvl_q[slot_q], slot_cfg[CFG_ATT +: 2]);

    // The snapshot below reads cfg_q, so a same-edge write lands next frame.
    if (cfg_we)
      cfg_d[cfg_addr] = cfg_data;

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          snap_lvl_d[SRC_A]    = ay_cha;
          snap_lvl_d[SRC_B]    = ay_chb;
          snap_lvl_d[SRC_C]    = ay_chc;
          snap_lvl_d[SRC_BEEP] = beep_level(ear, mic);
          snap_cfg_d           = cfg_q;
          snap_mute_d          = mute;
          acc_l_d              = '0;
          acc_r_d              = '0;
          slot_d               = 2'd0;
          state_d              = ST_ACC;
        end
      end
      ST_ACC: begin
        if (slot_cfg[CFG_L])
          acc_l_d = acc_l_q + term;
        if (slot_cfg[CFG_R])
          acc_r_d = acc_r_q + term;
        slot_d = slot_q + 2'd1;
        if (slot_q == 2'd3)
          state_d = ST_SAT;
      end
      ST_SAT: begin
        audio_l_d = saturate(acc_l_q, snap_mute_q);
        audio_r_d = saturate(acc_r_q, snap_mute_q);
        valid_d   = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      slot_q      <= 2'd0;
      cfg_q       <= CFG_DEFAULT;
      snap_cfg_q  <= CFG_DEFAULT;
      snap_lvl_q  <= '0;
      snap_mute_q <= 1'b0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      audio_l_q   <= '0;
      audio_r_q   <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      cfg_q       <= cfg_d;
      snap_cfg_q  <= snap_cfg_d;
      snap_lvl_q  <= snap_lvl_d;
      snap_mute_q <= snap_mute_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      audio_l_q   <= audio_l_d;
      audio_r_q   <= audio_r_d;
      valid_q     <= valid_d;
    end
  end

  assign audio_l     = audio_l_q;
  assign audio_r     = audio_r_q;
  assign audio_valid = valid_q;

endmodule

`default_nettype wire
